// File: rtl/cordic_scheduler_pkg.sv
// Shared FSM/mode encodings and default sizing for the CORDIC request scheduler.
package cordic_sched_pkg;

  localparam int DW_DEF     = 16;
  localparam int N_ITER_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

endpackage

// File: rtl/cordic_scheduler_if.sv
// Requester-side bundle: per-requester req/operands/mode in, one-hot gnt/done and shared result out.
interface cordic_scheduler_if
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = DW_DEF
);

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_mode;
  logic [NUM_REQ*DW-1:0] req_x;
  logic [NUM_REQ*DW-1:0] req_y;
  logic [NUM_REQ*DW-1:0] req_z;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [DW-1:0]         res_x;
  logic [DW-1:0]         res_y;
  logic [DW-1:0]         res_z;

  modport master (
    output req, req_mode, req_x, req_y, req_z,
    input  gnt, done, res_x, res_y, res_z
  );

  modport slave (
    input  req, req_mode, req_x, req_y, req_z,
    output gnt, done, res_x, res_y, res_z
  );

endinterface

// File: rtl/cordic_scheduler_arb.sv
// Combinational winner pick, zero latency; round-robin from a pointer with CORDIC_SCHED_RR_EN,
// fixed lowest-index priority otherwise. No backpressure: the caller pulses take on a grant.
module cordic_req_arb #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic               any,
  output logic [IW-1:0]      win_idx
);

  logic [IW-1:0] start;

`ifdef CORDIC_SCHED_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (take) begin
      ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign start = ptr_q;
`else
  logic unused_fixed;
  assign unused_fixed = ^{clk, reset, take};
  assign start        = '0;
`endif

  assign any = |req;

  // Walk the search order backwards so the first requester in order is the last write.
  always_comb begin
    int            j;
    logic [IW-1:0] idx;
    win_idx = '0;
    j       = 0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      idx = IW'(j);
      if (req[idx]) begin
        win_idx = idx;
      end
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Time-shares one iterative CORDIC datapath; done follows gnt by N_ITER+1 cycles, period N_ITER+3.
// No backpressure: requesters hold req until gnt. CORDIC_SCHED_RR_EN selects round-robin arbitration.
module cordic_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = DW_DEF,
  parameter int N_ITER  = N_ITER_DEF
) (
  input  logic              clk,
  input  logic              reset,
  cordic_scheduler_if.slave rq,
  output logic [DW-1:0]     dp_x_in,
  output logic [DW-1:0]     dp_y_in,
  output logic [DW-1:0]     dp_z_in,
  output logic              dp_mode,
  output logic              selmx,
  output logic              selmy,
  output logic              selmz,
  output logic [3:0]        i,
  input  logic [DW-1:0]     dp_x_out,
  input  logic [DW-1:0]     dp_y_out,
  input  logic [DW-1:0]     dp_z_out,
  output logic              busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [3:0]         i_q, i_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] own_q, own_d;
  logic [DW-1:0]      x_in_q, x_in_d, y_in_q, y_in_d, z_in_q, z_in_d;
  logic [DW-1:0]      res_x_q, res_x_d, res_y_q, res_y_d, res_z_q, res_z_d;
  mode_e              mode_q, mode_d;

  logic               any;
  logic               take;
  logic [IW-1:0]      win_idx;

  assign take = (state_q == ST_IDLE) && any;

  cordic_req_arb #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (rq.req),
    .take    (take),
    .any     (any),
    .win_idx (win_idx)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    gnt_d   = '0;
    done_d  = '0;
    own_d   = own_q;
    x_in_d  = x_in_q;
    y_in_d  = y_in_q;
    z_in_d  = z_in_q;
    mode_d  = mode_q;
    res_x_d = res_x_q;
    res_y_d = res_y_q;
    res_z_d = res_z_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          gnt_d[win_idx] = 1'b1;
          own_d          = '0;
          own_d[win_idx] = 1'b1;
          x_in_d         = rq.req_x[int'(win_idx)*DW +: DW];
          y_in_d         = rq.req_y[int'(win_idx)*DW +: DW];
          z_in_d         = rq.req_z[int'(win_idx)*DW +: DW];
          mode_d         = mode_e'(rq.req_mode[win_idx]);
          i_d            = '0;
          state_d        = ST_LOAD;
        end
      end
      ST_LOAD: begin
        i_d     = 4'd1;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        // >= rather than == so a corrupted count can never run past N_ITER.
        if (i_q >= 4'(N_ITER)) begin
          res_x_d = dp_x_out;
          res_y_d = dp_y_out;
          res_z_d = dp_z_out;
          done_d  = own_q;
          i_d     = '0;
          state_d = ST_DONE;
        end else begin
          i_d = i_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        i_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      own_q   <= '0;
      x_in_q  <= '0;
      y_in_q  <= '0;
      z_in_q  <= '0;
      mode_q  <= MODE_ROT;
      res_x_q <= '0;
      res_y_q <= '0;
      res_z_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      own_q   <= own_d;
      x_in_q  <= x_in_d;
      y_in_q  <= y_in_d;
      z_in_q  <= z_in_d;
      mode_q  <= mode_d;
      res_x_q <= res_x_d;
      res_y_q <= res_y_d;
      res_z_q <= res_z_d;
    end
  end

  assign rq.gnt   = gnt_q;
  assign rq.done  = done_q;
  assign rq.res_x = res_x_q;
  assign rq.res_y = res_y_q;
  assign rq.res_z = res_z_q;

  assign dp_x_in = x_in_q;
  assign dp_y_in = y_in_q;
  assign dp_z_in = z_in_q;
  assign dp_mode = mode_q;
  assign i       = i_q;
  assign selmx   = (state_q == ST_ITER);
  assign selmy   = (state_q == ST_ITER);
  assign selmz   = (state_q == ST_ITER);
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: behavioural CORDIC datapath plus a scoreboard queue popped by a
// negedge monitor that checks grant order, per-cycle i/sel sequencing, operands and results.
`timescale 1ns/1ps
module tb_cordic_scheduler;
  import cordic_sched_pkg::*;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int NI = 10;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } v3_t;

  typedef struct {
    int          idx;
    logic [15:0] ix;
    logic [15:0] iy;
    logic [15:0] iz;
    logic        m;
    v3_t         res;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] dp_x_in, dp_y_in, dp_z_in;
  logic        dp_mode, selmx, selmy, selmz, busy;
  logic [3:0]  i;
  logic [15:0] dp_x_out, dp_y_out, dp_z_out;

  logic [15:0] op_x [NR];
  logic [15:0] op_y [NR];
  logic [15:0] op_z [NR];
  logic        op_m [NR];

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   inflight = 0;
  int   ph       = 0;
  exp_t cur;

  cordic_scheduler_if #(.NUM_REQ(NR), .DW(DW)) rq ();

  cordic_scheduler #(.NUM_REQ(NR), .DW(DW), .N_ITER(NI)) dut (
    .clk      (clk),
    .reset    (reset),
    .rq       (rq),
    .dp_x_in  (dp_x_in),
    .dp_y_in  (dp_y_in),
    .dp_z_in  (dp_z_in),
    .dp_mode  (dp_mode),
    .selmx    (selmx),
    .selmy    (selmy),
    .selmz    (selmz),
    .i        (i),
    .dp_x_out (dp_x_out),
    .dp_y_out (dp_y_out),
    .dp_z_out (dp_z_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rq.req_x    = '0;
    rq.req_y    = '0;
    rq.req_z    = '0;
    rq.req_mode = '0;
    for (int k = 0; k < NR; k++) begin
      rq.req_x[k*DW +: DW] = op_x[k];
      rq.req_y[k*DW +: DW] = op_y[k];
      rq.req_z[k*DW +: DW] = op_z[k];
      rq.req_mode[k]       = op_m[k];
    end
  end

  // Angle units: 0x4000 is a quarter turn.
  function automatic logic [15:0] atan_of(input int s);
    logic [15:0] r;
    case (s)
      0: r = 16'd8192;  1: r = 16'd4836;  2: r = 16'd2555;  3: r = 16'd1297;
      4: r = 16'd651;   5: r = 16'd326;   6: r = 16'd163;   7: r = 16'd81;
      8: r = 16'd41;    9: r = 16'd20;    10: r = 16'd10;   11: r = 16'd5;
      12: r = 16'd3;    13: r = 16'd1;    14: r = 16'd1;    default: r = 16'd0;
    endcase
    return r;
  endfunction

  function automatic v3_t cstep(input v3_t v, input logic m, input int s);
    logic signed [15:0] xs, ys;
    logic               neg;
    v3_t                r;
    xs  = $signed(v.x) >>> s;
    ys  = $signed(v.y) >>> s;
    neg = m ? ~v.y[15] : v.z[15];
    if (!neg) begin
      r.x = v.x - ys;  r.y = v.y + xs;  r.z = v.z - atan_of(s);
    end else begin
      r.x = v.x + ys;  r.y = v.y - xs;  r.z = v.z + atan_of(s);
    end
    return r;
  endfunction

  // Value the datapath presents in the last ITER cycle: micro-rotations 1..NI-1 applied.
  function automatic v3_t cref(input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] z, input logic m);
    v3_t v;
    v = {x, y, z};
    for (int s = 1; s < NI; s++) v = cstep(v, m, s);
    return v;
  endfunction

  function automatic logic [NR-1:0] onehot(input int k);
    return NR'(1) << k;
  endfunction

  v3_t dp_q;
  always @(posedge clk) begin
    if (!selmx) dp_q <= {dp_x_in, dp_y_in, dp_z_in};
    else        dp_q <= cstep(dp_q, dp_mode, int'(i));
  end
  assign dp_x_out = dp_q.x;
  assign dp_y_out = dp_q.y;
  assign dp_z_out = dp_q.z;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic expect_op(input int k);
    exp_t e;
    e.idx = k;
    e.ix  = op_x[k];
    e.iy  = op_y[k];
    e.iz  = op_z[k];
    e.m   = op_m[k];
    e.res = cref(op_x[k], op_y[k], op_z[k], op_m[k]);
    exp_q.push_back(e);
  endtask

  // Hold mask until n grants are seen, checking back-to-back spacing; drop req at the last grant.
  task automatic hold(input logic [NR-1:0] mask, input int n);
    int got, last, t, budget;
    got    = 0;
    last   = 0;
    t      = 0;
    budget = n * (NI + 3) + 20;
    rq.req = mask;
    while (got < n && budget > 0) begin
      @(negedge clk);
      t++;
      budget--;
      if (rq.gnt != '0) begin
        if (got > 0) chk("grant_period", 64'(t - last), 64'(NI + 3));
        last = t;
        got++;
      end
    end
    if (got < n) chk("grant_timeout", 64'(got), 64'(n));
    rq.req = '0;
  endtask

  task automatic wait_idle();
    int b;
    b = 4 * (NI + 3);
    while (busy && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  logic [3:0] exp_i;
  logic       exp_sel;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        chk("rst_ctrl", 64'({rq.gnt, rq.done, busy, i, selmx, selmy, selmz, dp_mode}), '0);
        chk("rst_res", 64'({rq.res_x, rq.res_y, rq.res_z}), '0);
        chk("rst_dp_in", 64'({dp_x_in, dp_y_in, dp_z_in}), '0);
        inflight = 0;
      end else begin
        if (!inflight && rq.gnt != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_gnt", 64'(rq.gnt), '0);
          end else begin
            cur      = exp_q.pop_front();
            inflight = 1;
            ph       = 0;
          end
        end
        if (inflight) begin
          exp_i   = (ph >= 1 && ph <= NI) ? 4'(ph) : 4'd0;
          exp_sel = (ph >= 1 && ph <= NI);
          chk("gnt", 64'(rq.gnt), 64'((ph == 0) ? onehot(cur.idx) : '0));
          chk("done", 64'(rq.done), 64'((ph == NI + 1) ? onehot(cur.idx) : '0));
          chk("i_sel", 64'({i, selmx, selmy, selmz}), 64'({exp_i, {3{exp_sel}}}));
          chk("busy", 64'(busy), 64'(1));
          chk("dp_in", 64'({dp_x_in, dp_y_in, dp_z_in, dp_mode}),
              64'({cur.ix, cur.iy, cur.iz, cur.m}));
          if (ph == NI + 1) begin
            chk("res", 64'({rq.res_x, rq.res_y, rq.res_z}), 64'(cur.res));
            inflight = 0;
          end
          ph++;
        end else begin
          chk("idle", 64'({rq.gnt, rq.done, busy, i, selmx, selmy, selmz}), '0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    reset  = 1'b0;
    rq.req = '0;
    op_x[0] = 16'h4000; op_y[0] = 16'h0000; op_z[0] = 16'h1000; op_m[0] = 1'b0;
    op_x[1] = 16'h3000; op_y[1] = 16'h1000; op_z[1] = 16'h0000; op_m[1] = 1'b1;
    op_x[2] = 16'h2000; op_y[2] = 16'hE000; op_z[2] = 16'hF000; op_m[2] = 1'b0;
    op_x[3] = 16'h1800; op_y[3] = 16'h0800; op_z[3] = 16'h0400; op_m[3] = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    // All four requesting continuously.
`ifdef CORDIC_SCHED_RR_EN
    expect_op(0); expect_op(1); expect_op(2); expect_op(3);
`else
    expect_op(0); expect_op(0); expect_op(0); expect_op(0);
`endif
    hold(4'b1111, 4);
    wait_idle();

    // Single rotation request x=0x4000, y=0, z=0x1000.
    expect_op(0);
    hold(4'b0001, 1);
    wait_idle();

    // Requesters 1 and 3 held, then only 3.
`ifdef CORDIC_SCHED_RR_EN
    expect_op(1); expect_op(3); expect_op(1);
`else
    expect_op(1); expect_op(1); expect_op(1);
`endif
    hold(4'b1010, 3);
    expect_op(3);
    hold(4'b1000, 1);
    wait_idle();

    // One-cycle req[2] pulse during ITER must be ignored.
    expect_op(0);
    hold(4'b0001, 1);
    repeat (3) @(negedge clk);
    rq.req = 4'b0100;
    @(negedge clk);
    rq.req = '0;
    wait_idle();
    repeat (5) @(negedge clk);

    // Reset in the i==5 cycle aborts the vectoring operation.
    expect_op(1);
    hold(4'b0010, 1);
    begin
      int b;
      b = 2 * NI;
      while (i != 4'd4 && b > 0) begin
        @(negedge clk);
        b--;
      end
      if (i != 4'd4) chk("reach_i4_timeout", 64'(i), 64'(4));
    end
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (NI + 5) @(negedge clk);

    // Recovery after reset with a vectoring request from requester 3.
    expect_op(3);
    hold(4'b1000, 1);
    wait_idle();

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    chk("no_inflight", 64'(inflight), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
